// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles 32-bit words from a byte-wide memory port and hands {pc, inst} to IF/ID.
// Optional direct-mapped one-word-line instruction cache enabled by defining IF_ICACHE_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          ICACHE_IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_target_in,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_byte_valid_in,
  input  logic [7:0]  mem_byte_in,
  output logic        inst_valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic        mem_req_nxt;
  logic [31:0] mem_addr_nxt;
  logic        inst_valid_nxt;
  logic [31:0] pc_out_nxt;
  logic [31:0] inst_nxt;
  logic        hit;
  logic [31:0] hit_data;

`ifdef IF_ICACHE_EN
  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 30 - ICACHE_IDX_W;

  logic [31:0]             line_data [LINES];
  logic [TAG_W-1:0]        line_tag  [LINES];
  logic [LINES-1:0]        line_vld;
  logic [ICACHE_IDX_W-1:0] idx;
  logic [TAG_W-1:0]        tag;
  logic                    fill;

  assign idx      = pc[ICACHE_IDX_W+1:2];
  assign tag      = pc[31:ICACHE_IDX_W+2];
  assign hit      = line_vld[idx] && (line_tag[idx] == tag);
  assign hit_data = line_data[idx];
  // A line is filled only when the fourth byte lands and no redirect cancels it.
  assign fill     = (state == FETCH) && mem_byte_valid_in && !branch_taken_in && (cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      line_vld <= '0;
    end else if (fill) begin
      line_vld[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      line_data[idx] <= inst_nxt;
      line_tag[idx]  <= tag;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    cnt_nxt        = cnt;
    mem_req_nxt    = mem_req_out;
    mem_addr_nxt   = mem_addr_out;
    inst_valid_nxt = inst_valid_out;
    pc_out_nxt     = pc_out;
    inst_nxt       = inst_out;
    if (branch_taken_in) begin
      pc_nxt         = branch_target_in;
      state_nxt      = IDLE;
      mem_req_nxt    = 1'b0;
      inst_valid_nxt = 1'b0;
      cnt_nxt        = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            inst_nxt       = hit_data;
            pc_out_nxt     = pc;
            pc_nxt         = pc + 32'd4;
            inst_valid_nxt = 1'b1;
            state_nxt      = HOLD;
          end else begin
            mem_req_nxt  = 1'b1;
            mem_addr_nxt = pc;
            cnt_nxt      = 2'd0;
            state_nxt    = FETCH;
          end
        end
        FETCH: begin
          if (mem_byte_valid_in) begin
            inst_nxt[{cnt, 3'b000} +: 8] = mem_byte_in;
            cnt_nxt      = cnt + 2'd1;
            mem_addr_nxt = pc + {30'd0, cnt} + 32'd1;
            if (cnt == 2'd3) begin
              mem_req_nxt    = 1'b0;
              pc_out_nxt     = pc;
              pc_nxt         = pc + 32'd4;
              inst_valid_nxt = 1'b1;
              state_nxt      = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_in) begin
            inst_valid_nxt = 1'b0;
            state_nxt      = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      cnt            <= 2'd0;
      mem_req_out    <= 1'b0;
      mem_addr_out   <= 32'd0;
      inst_valid_out <= 1'b0;
      pc_out         <= 32'd0;
      inst_out       <= 32'd0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      cnt            <= cnt_nxt;
      mem_req_out    <= mem_req_nxt;
      mem_addr_out   <= mem_addr_nxt;
      inst_valid_out <= inst_valid_nxt;
      pc_out         <= pc_out_nxt;
      inst_out       <= inst_nxt;
    end
  end

endmodule
